// File: rtl/range_frame_sequencer_if.sv
// Byte-stream input, frame request and range-finder output bundle for range_frame_sequencer.
// The master drives the stream and requests; the slave (the sequencer) drives ready, frame outputs and status.
interface range_frame_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 5
);
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic             start;
    logic [LEN_W-1:0] frame_len;
    logic [WIDTH-1:0] data_out;
    logic             go;
    logic             finish;
    logic             busy;
    logic             err;

    modport master (
        output in_data, in_valid, start, frame_len,
        input  in_ready, data_out, go, finish, busy, err
    );

    modport slave (
        input  in_data, in_valid, start, frame_len,
        output in_ready, data_out, go, finish, busy, err
    );
endinterface

// File: rtl/range_frame_sequencer.sv
// Buffers a byte stream and plays out N-byte frames marked by go/finish; RANGE_FRAME_GAP_EN adds a 2-cycle gap after finish.
// Latency: go/data_out 2 cycles after the fill threshold is met; finish registered 1 cycle after the last sample.
// Backpressure: in_ready drops only when the FIFO is full; a frame never stalls once started.
module range_frame_sequencer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16,
    parameter int LEN_W = 5
) (
    input  logic clk,
    input  logic rst_n,
    range_frame_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_GO,
        S_STREAM,
        S_FIN,
        S_GAP
    } state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [CW-1:0]    count;
    logic             push, pop;
    logic [LEN_W-1:0] n_len, n_nxt;
    logic [LEN_W-1:0] rem, rem_nxt;
    logic             err_q, err_nxt;
    logic             go_q, go_nxt;
    logic             fin_q, fin_nxt;
    logic [WIDTH-1:0] data_q;
`ifdef RANGE_FRAME_GAP_EN
    logic             gap_cnt, gap_nxt;
`endif

    assign bus.in_ready = (count < CW'(DEPTH));
    assign push         = bus.in_valid && bus.in_ready;
    assign bus.data_out = data_q;
    assign bus.go       = go_q;
    assign bus.finish   = fin_q;
    assign bus.busy     = (state != S_IDLE);
    assign bus.err      = err_q;

    // Storage carries no reset: emptying the pointers/count discards contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            n_len  <= '0;
            rem    <= '0;
            err_q  <= 1'b0;
            go_q   <= 1'b0;
            fin_q  <= 1'b0;
            data_q <= '0;
`ifdef RANGE_FRAME_GAP_EN
            gap_cnt <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            n_len <= n_nxt;
            rem   <= rem_nxt;
            err_q <= err_nxt;
            go_q  <= go_nxt;
            fin_q <= fin_nxt;
            if (pop) begin
                data_q <= mem[rd_ptr];
            end
`ifdef RANGE_FRAME_GAP_EN
            gap_cnt <= gap_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        n_nxt     = n_len;
        rem_nxt   = rem;
        err_nxt   = err_q;
        go_nxt    = 1'b0;
        fin_nxt   = 1'b0;
        pop       = 1'b0;
`ifdef RANGE_FRAME_GAP_EN
        gap_nxt   = gap_cnt;
`endif
        case (state)
            S_IDLE: begin
                if (bus.start) begin
                    if (bus.frame_len == '0 || bus.frame_len > LEN_W'(DEPTH)) begin
                        err_nxt = 1'b1;
                    end else begin
                        n_nxt     = bus.frame_len;
                        state_nxt = S_FILL;
                    end
                end
            end
            S_FILL: begin
                // Whole frame must be resident so streaming never stalls.
                if (LEN_W'(count) >= n_len) begin
                    state_nxt = S_GO;
                end
            end
            S_GO: begin
                pop       = 1'b1;
                go_nxt    = 1'b1;
                rem_nxt   = n_len - 1'b1;
                state_nxt = (n_len == LEN_W'(1)) ? S_FIN : S_STREAM;
            end
            S_STREAM: begin
                pop     = 1'b1;
                rem_nxt = rem - 1'b1;
                if (rem == LEN_W'(1)) begin
                    state_nxt = S_FIN;
                end
            end
            S_FIN: begin
                fin_nxt = 1'b1;
`ifdef RANGE_FRAME_GAP_EN
                gap_nxt   = 1'b0;
                state_nxt = S_GAP;
`else
                state_nxt = S_IDLE;
`endif
            end
`ifdef RANGE_FRAME_GAP_EN
            S_GAP: begin
                gap_nxt = 1'b1;
                if (gap_cnt) begin
                    state_nxt = S_IDLE;
                end
            end
`endif
            default: state_nxt = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_range_frame_sequencer.sv
// Directed bench for range_frame_sequencer: a per-cycle vector table for the basic frame and
// length errors, then hand-written sequences for fill wait, full FIFO, N=1, pointer wrap and mid-frame reset.
module tb_range_frame_sequencer;
    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_bad;

    range_frame_sequencer_if #(.WIDTH(8), .LEN_W(5)) bus();

    range_frame_sequencer #(.WIDTH(8), .DEPTH(16), .LEN_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit       rst;
        bit       vld;
        bit [7:0] dat;
        bit       st;
        bit [4:0] len;
        bit [7:0] e_dat;
        bit       e_go;
        bit       e_fin;
        bit       e_busy;
        bit       e_rdy;
        bit       e_err;
    } vec_t;

    vec_t vt[13];

    function automatic vec_t mk(bit r, bit v, bit [7:0] d, bit s, bit [4:0] l,
                                bit [7:0] ed, bit eg, bit ef, bit eb, bit er, bit ee);
        vec_t x;
        x.rst = r; x.vld = v; x.dat = d; x.st = s; x.len = l;
        x.e_dat = ed; x.e_go = eg; x.e_fin = ef; x.e_busy = eb; x.e_rdy = er; x.e_err = ee;
        return x;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit v, input bit [7:0] d, input bit s, input bit [4:0] l);
        @(negedge clk);
        rst_n         = r;
        bus.in_valid  = v;
        bus.in_data   = d;
        bus.start     = s;
        bus.frame_len = l;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 8'h00, 1'b0, 5'd0);
    endtask

    task automatic push(input bit [7:0] d);
        step(1'b1, 1'b1, d, 1'b0, 5'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the end, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        clk           = 1'b0;
        rst_n         = 1'b0;
        n_cmp         = 0;
        n_bad         = 0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.start     = 1'b0;
        bus.frame_len = '0;

        //          rst vld dat    st len    e_dat  go fin busy rdy err
        vt[0]  = mk(0,  0,  8'h00, 0, 5'd0,  8'h00, 0, 0,  0,   1,  0);
        vt[1]  = mk(1,  1,  8'h10, 0, 5'd0,  8'h00, 0, 0,  0,   1,  0);
        vt[2]  = mk(1,  1,  8'h20, 0, 5'd0,  8'h00, 0, 0,  0,   1,  0);
        vt[3]  = mk(1,  1,  8'h30, 0, 5'd0,  8'h00, 0, 0,  0,   1,  0);
        vt[4]  = mk(1,  0,  8'h00, 1, 5'd3,  8'h00, 0, 0,  1,   1,  0);
        vt[5]  = mk(1,  0,  8'h00, 0, 5'd0,  8'h00, 0, 0,  1,   1,  0);
        vt[6]  = mk(1,  0,  8'h00, 0, 5'd0,  8'h10, 1, 0,  1,   1,  0);
        vt[7]  = mk(1,  0,  8'h00, 0, 5'd0,  8'h20, 0, 0,  1,   1,  0);
        vt[8]  = mk(1,  0,  8'h00, 0, 5'd0,  8'h30, 0, 0,  1,   1,  0);
        vt[9]  = mk(1,  0,  8'h00, 0, 5'd0,  8'h30, 0, 1,  0,   1,  0);
        vt[10] = mk(1,  0,  8'h00, 1, 5'd0,  8'h30, 0, 0,  0,   1,  1);
        vt[11] = mk(1,  0,  8'h00, 1, 5'd17, 8'h30, 0, 0,  0,   1,  1);
        vt[12] = mk(1,  0,  8'h00, 0, 5'd0,  8'h30, 0, 0,  0,   1,  1);

        for (int i = 0; i < 13; i++) begin
            step(vt[i].rst, vt[i].vld, vt[i].dat, vt[i].st, vt[i].len);
            chk($sformatf("vec%0d data_out", i), bus.data_out, vt[i].e_dat);
            chk($sformatf("vec%0d go", i),       bus.go,       vt[i].e_go);
            chk($sformatf("vec%0d finish", i),   bus.finish,   vt[i].e_fin);
            chk($sformatf("vec%0d busy", i),     bus.busy,     vt[i].e_busy);
            chk($sformatf("vec%0d in_ready", i), bus.in_ready, vt[i].e_rdy);
            chk($sformatf("vec%0d err", i),      bus.err,      vt[i].e_err);
        end

        // Frame requested before enough data: waits in FILL.
        push(8'h41);
        push(8'h42);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd4);
        chk("fill busy", bus.busy, 1);
        for (int i = 0; i < 5; i++) begin
            idle();
            chk("fill wait go", bus.go, 0);
        end
        push(8'h43);
        push(8'h44);
        chk("fill after 4th push go", bus.go, 0);
        idle();
        chk("fill go timing", bus.go, 0);
        idle();
        chk("fill go", bus.go, 1);
        chk("fill data0", bus.data_out, 8'h41);
        chk("fill err sticky", bus.err, 1);
        for (int k = 1; k < 4; k++) begin
            idle();
            chk("fill stream data", bus.data_out, 8'h41 + k);
            chk("fill stream go", bus.go, 0);
            chk("fill stream finish", bus.finish, 0);
        end
        idle();
        chk("fill finish", bus.finish, 1);
        chk("fill finish data", bus.data_out, 8'h44);
        chk("fill finish busy", bus.busy, 0);

        // Full FIFO and a DEPTH-long frame.
        for (int i = 0; i < 16; i++) push(8'h80 + i[7:0]);
        chk("full in_ready", bus.in_ready, 0);
        push(8'hEE);
        push(8'hEE);
        chk("full hold in_ready", bus.in_ready, 0);
        chk("full hold count", dut.count, 16);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd16);
        idle();
        for (int k = 0; k < 16; k++) begin
            idle();
            chk("full stream data", bus.data_out, 8'h80 + k);
            chk("full stream go", bus.go, (k == 0) ? 1 : 0);
        end
        idle();
        chk("full finish", bus.finish, 1);
        chk("full finish data", bus.data_out, 8'h8F);
        chk("full after in_ready", bus.in_ready, 1);
        chk("full after count", dut.count, 0);

        // Single-sample frame.
        push(8'hAA);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd1);
        idle();
        idle();
        chk("n1 go", bus.go, 1);
        chk("n1 data", bus.data_out, 8'hAA);
        chk("n1 no finish with go", bus.finish, 0);
        idle();
        chk("n1 finish", bus.finish, 1);
        chk("n1 no go with finish", bus.go, 0);
        chk("n1 finish data", bus.data_out, 8'hAA);

        // Concurrent pushes while streaming, across pointer wrap.
        for (int i = 0; i < 14; i++) push(8'hC0 + i[7:0]);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd14);
        for (int c = 0; c < 16; c++) begin
            step(1'b1, (c < 6), 8'hD0 + c[7:0], 1'b0, 5'd0);
            chk("wrap go", bus.go, (c == 1) ? 1 : 0);
            chk("wrap finish", bus.finish, (c == 15) ? 1 : 0);
            if (c >= 1 && c <= 14) chk("wrap data", bus.data_out, 8'hC0 + c - 1);
        end
        chk("wrap finish data", bus.data_out, 8'hCD);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd6);
        idle();
        for (int k = 0; k < 6; k++) begin
            idle();
            chk("wrap2 data", bus.data_out, 8'hD0 + k);
            chk("wrap2 go", bus.go, (k == 0) ? 1 : 0);
        end
        idle();
        chk("wrap2 finish", bus.finish, 1);
        chk("wrap2 finish data", bus.data_out, 8'hD5);

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) push(8'hE0 + i[7:0]);
        step(1'b1, 1'b0, 8'h00, 1'b1, 5'd4);
        idle();
        idle();
        chk("rst pre go", bus.go, 1);
        chk("rst pre data", bus.data_out, 8'hE0);
        idle();
        chk("rst pre stream data", bus.data_out, 8'hE1);
        step(1'b0, 1'b0, 8'h00, 1'b0, 5'd0);
        chk("rst data_out", bus.data_out, 0);
        chk("rst go", bus.go, 0);
        chk("rst finish", bus.finish, 0);
        chk("rst busy", bus.busy, 0);
        chk("rst err", bus.err, 0);
        chk("rst in_ready", bus.in_ready, 1);
        chk("rst count", dut.count, 0);
        for (int i = 0; i < 4; i++) begin
            idle();
            chk("post rst finish", bus.finish, 0);
            chk("post rst busy", bus.busy, 0);
            chk("post rst data", bus.data_out, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/range_frame_sequencer.md
Name: range_frame_sequencer

Overview:
- Upstream feeder for the range-finding stage.
- Buffers an incoming byte stream in a small FIFO and, on request, plays out one frame of N bytes on consecutive cycles.
- Frames it with a `go` pulse on the first byte and a `finish` pulse after the last byte, so the downstream stage never sees gaps inside a frame.
- Sits between the chip input pins (`ui_in` plus handshake on `uio`) and the range finder's `data_in`/`go`/`finish` inputs.

Parameters:
- WIDTH, 8, sample width in bits.
- DEPTH, 16, FIFO depth in samples; must be a power of 2, at least 2.
- LEN_W, 5, width of `frame_len`; must satisfy 2^LEN_W > DEPTH.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- in_data  input  WIDTH  sample to buffer.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  FIFO can accept a sample; a push happens when in_valid && in_ready.
- start  input  1  frame request, sampled in IDLE only.
- frame_len  input  LEN_W  frame length N, captured on the accepted start.
- data_out  output  WIDTH  sample to the range finder.
- go  output  1  one-cycle pulse coincident with sample 0.
- finish  output  1  one-cycle pulse on the cycle after the last sample.
- busy  output  1  high in every state except IDLE.
- err  output  1  sticky bad-length flag; cleared only by reset.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - FIFO empties; state becomes IDLE.
  - data_out=0, go=0, finish=0, busy=0, err=0.
  - in_ready=1 from the first cycle after reset.
- FIFO:
  - Registered pointers and a (log2(DEPTH)+1)-bit count.
  - in_ready = (count < DEPTH).
  - Simultaneous push and pop in one cycle leaves count unchanged; both operations take effect.
  - Pointers wrap modulo DEPTH.
  - A push while full cannot occur, because in_ready=0 when full.
- FSM states: IDLE, FILL, GO, STREAM, FIN.
- IDLE:
  - start=1 with 1 <= frame_len <= DEPTH: latch N=frame_len, go to FILL.
  - start=1 with frame_len=0 or frame_len>DEPTH: set err=1, stay in IDLE.
- FILL: wait until count >= N, then go to GO next cycle. Pushes continue during FILL.
- GO:
  - Pop the FIFO head.
  - data_out is registered and updated on the same edge that leaves GO; go=1 for that cycle (1 cycle after leaving FILL).
  - If N=1, next state is FIN; otherwise STREAM with remaining = N-1.
- STREAM:
  - Pop one sample per cycle into data_out; go=0.
  - Decrement remaining; on the last pop, next state is FIN.
  - No stalls: all N samples were buffered before GO.
- FIN:
  - finish=1 for exactly one cycle; data_out holds the last sample.
  - Then IDLE.
- Output timing:
  - A frame of N occupies exactly N+1 output cycles, from the go cycle through the finish cycle inclusive.
  - go and finish are never high in the same cycle.
- data_out holds its last value whenever not streaming.
- Pushes are accepted in every state, including while streaming.
- start outside IDLE is ignored and is not queued.
- Reset mid-frame: the frame is aborted, no finish is issued, and FIFO contents are discarded.

Optional Feature:
- Macro: RANGE_FRAME_GAP_EN.
- Defined:
  - FIN is followed by a GAP state lasting 2 cycles, with busy=1, before IDLE.
  - This guarantees at least 3 cycles between a finish and the next go.
- Undefined:
  - FIN goes directly to IDLE.
  - The minimum is finish -> IDLE (start sampled) -> FILL -> GO, i.e. go at least 3 cycles after finish when the data is already buffered.

Test Plan:
- Reset, then push 0x10,0x20,0x30, then start with frame_len=3 -> go with data_out=0x10; then 0x20, 0x30; finish on the next cycle with data_out=0x30; busy falls.
- start with frame_len=4 while only 2 samples are buffered; push 2 more 5 cycles later -> no go until count=4; then 4 contiguous samples and finish.
- Push DEPTH=16 samples with no start -> in_ready=0 after the 16th; in_valid held high adds no samples; frame_len=16 streams all in order, then in_ready=1.
- start with frame_len=0, then with frame_len=17 -> err=1 sticky, state stays IDLE, go never asserted; a later valid frame still runs with err=1.
- frame_len=1 with 0xAA buffered -> go with 0xAA, finish the next cycle; pushes concurrent with streaming keep correct order across pointer wrap (pre-fill 14, play 14, push 6, play 6).
- Assert rst_n=0 mid-STREAM -> next cycle all outputs at reset values, count=0, no finish pulse.
